// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives the instruction bus and
// presents the fetched instruction (or a held copy) to the IF/ID register.
package fetch_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_data_t;

endpackage

module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output fetch_data_t dataF_nxt,
    output logic        busy
);

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      stateR, stateNext;
    logic [63:0] pcR, pcNext;
    logic [63:0] tgtPcR, tgtPcNext;
    logic [63:0] bufPcR, bufPcNext;
    logic [31:0] bufInstrR, bufInstrNext;

    // Sequential PC advance; wraps modulo 2^64 with no alignment check.
    function automatic logic [63:0] incPc(input logic [63:0] pcIn);
        return pcIn + 64'd4;
    endfunction

    // The transaction completes on data_ok alone; addr_ok is informational here.
    logic unusedAddrOk;
    assign unusedAddrOk = iresp.addr_ok;

    // State, PC and buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateR    <= REQ;
            pcR       <= PC_RESET;
            tgtPcR    <= 64'd0;
            bufPcR    <= 64'd0;
            bufInstrR <= 32'd0;
        end else begin
            stateR    <= stateNext;
            pcR       <= pcNext;
            tgtPcR    <= tgtPcNext;
            bufPcR    <= bufPcNext;
            bufInstrR <= bufInstrNext;
        end
    end

    // Next-state logic and bus/pipeline outputs.
    always_comb begin
        stateNext    = stateR;
        pcNext       = pcR;
        tgtPcNext    = tgtPcR;
        bufPcNext    = bufPcR;
        bufInstrNext = bufInstrR;
        ireq         = '0;
        dataF_nxt    = '0;
        busy         = 1'b0;

        case (stateR)
            REQ: begin
                ireq.valid = 1'b1;
                ireq.addr  = pcR;
                busy       = ~iresp.data_ok;
                if (iresp.data_ok) begin
                    // A same-cycle redirect squashes the instruction just returned.
                    dataF_nxt.valid = ~redirect;
                    dataF_nxt.pc    = pcR;
                    dataF_nxt.instr = iresp.data;
                    if (redirect) begin
                        pcNext = redirect_pc;
                    end else if (!stall) begin
                        pcNext = incPc(pcR);
                    end else begin
                        bufPcNext    = pcR;
                        bufInstrNext = iresp.data;
                        stateNext    = HOLD;
                    end
                end else if (redirect) begin
                    tgtPcNext = redirect_pc;
                    stateNext = DISCARD;
                end else begin
                    stateNext = REQ;
                end
            end

            HOLD: begin
                dataF_nxt.valid = ~redirect;
                dataF_nxt.pc    = bufPcR;
                dataF_nxt.instr = bufInstrR;
                if (redirect) begin
                    pcNext    = redirect_pc;
                    stateNext = REQ;
                end else if (!stall) begin
                    pcNext    = incPc(bufPcR);
                    stateNext = REQ;
                end else begin
                    stateNext = HOLD;
                end
            end

            DISCARD: begin
                // Keep the stale request on the bus until its response drains.
                ireq.valid = 1'b1;
                ireq.addr  = pcR;
                busy       = ~iresp.data_ok;
                if (iresp.data_ok) begin
                    pcNext    = redirect ? redirect_pc : tgtPcR;
                    stateNext = REQ;
                end else if (redirect) begin
                    tgtPcNext = redirect_pc;
                end else begin
                    stateNext = DISCARD;
                end
            end

            default: begin
                stateNext = REQ;
            end
        endcase

        if (reset) begin
            ireq      = '0;
            dataF_nxt = '0;
        end else begin
            ireq      = ireq;
            dataF_nxt = dataF_nxt;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage pipeline. It owns the architectural fetch PC, drives the instruction bus (`ibus_req_t` / `ibus_resp_t`) and produces `dataF_nxt`, which the pipeline register latches into `dataF`. It absorbs bus latency, holds a fetched instruction while the pipeline is stalled, and applies branch redirects. A redirect never abandons a bus transaction mid-flight: any response still in flight is drained and discarded.

## Interface
- `PC_RESET`, default 64'h8000_0000: fetch PC loaded on reset.
- `clk`  in  1: clock.
- `reset`  in  1: reset. Synchronous, active-high.
- `ireq`  out  ibus_req_t: `valid` and `addr` (64-bit). `addr` stays stable while `valid` is high, until `data_ok` is seen.
- `iresp`  in  ibus_resp_t: `addr_ok`, `data_ok`, `data` (instruction in bits [31:0]).
- `stall`  in  1: downstream cannot accept this cycle. Equals `stalld | stallm`.
- `redirect`  in  1: taken branch or jump resolved. Same signal as `branch` on the pipeline register.
- `redirect_pc`  in  64: target PC, valid when `redirect` is high.
- `dataF_nxt`  out  fetch_data_t: `valid`, `pc` (64-bit), `instr` (32-bit).
- `busy`  out  1: high when the state is REQ or DISCARD and `data_ok` is low. Used by the hazard unit.

## Operation
- **Registers**
  - `pc`: address of the current or next request.
  - `tgt_pc`: pending redirect target, used only in DISCARD.
  - `buf_instr`, `buf_pc`: held instruction.
  - `state`: one of REQ, HOLD, DISCARD.
- **Reset**
  - `pc` = PC_RESET, `state` = REQ, buffers cleared.
  - While `reset` is high: `ireq.valid` = 0 and `dataF_nxt` = '0.
- **REQ**
  - Outputs: `ireq.valid` = 1, `ireq.addr` = `pc`.
  - On `data_ok`: `dataF_nxt` = {1, `pc`, `data[31:0]`} combinationally. Otherwise `dataF_nxt.valid` = 0.
  - `data_ok` & `redirect`: `dataF_nxt.valid` forced to 0, `pc` <= `redirect_pc`, stay in REQ.
  - `data_ok` & !`stall`: `pc` <= `pc` + 4, stay in REQ.
  - `data_ok` & `stall`: capture `buf_pc` = `pc` and `buf_instr`, go to HOLD.
  - !`data_ok` & `redirect`: `tgt_pc` <= `redirect_pc`, go to DISCARD.
  - `addr_ok` without `data_ok`: no state change; keep `valid` and `addr` held.
- **HOLD**
  - Outputs: `ireq.valid` = 0, `dataF_nxt` = {1, `buf_pc`, `buf_instr`}.
  - `redirect` (highest priority): `pc` <= `redirect_pc`, `dataF_nxt.valid` forced to 0, go to REQ.
  - !`stall`: `pc` <= `buf_pc` + 4, go to REQ.
  - Otherwise stay in HOLD.
- **DISCARD**
  - Outputs: `ireq.valid` = 1, `ireq.addr` = old `pc` (unchanged), `dataF_nxt.valid` = 0.
  - `redirect`: `tgt_pc` <= `redirect_pc`; the last redirect wins.
  - `data_ok`: the response is dropped and `pc` <= `tgt_pc`, or `redirect_pc` if `redirect` is high the same cycle. Go to REQ.
- **Arithmetic**
  - PC increment is 64-bit modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
  - No alignment check in this block.
- **Priority**
  - `reset` > `redirect` > `stall` > normal advance.
  - When `redirect` and `stall` are both high, the redirect is applied. The downstream pipeline register also zeros its `dataF` on `branch`.

## Timing
- Fetch latency equals bus latency: `dataF_nxt.valid` is asserted in the same cycle as `data_ok`.
- The next request is issued the cycle after acceptance.
- Peak throughput is one instruction per cycle with a zero-wait bus (`data_ok` in the request cycle).
- A redirect issues its first target request:
  - 1 cycle after `redirect` in REQ-with-`data_ok` or in HOLD;
  - 1 cycle after the draining `data_ok` in DISCARD.
- HOLD persists for any number of stall cycles. `buf_*` is stable and no bus activity occurs during HOLD.
- Reset asserted mid-transaction returns to REQ with PC_RESET. The outstanding bus response is not tracked; the bus is reset by the same `reset`.

## Test plan
- **Zero-wait stream**
  - Stimulus: `data_ok` every cycle, instructions 0x00000013, 0x00100093, …, `stall` = 0.
  - Required: `dataF_nxt` pcs 0x80000000, 0x80000004, 0x80000008 on consecutive cycles; `ireq.addr` advances by 4 each cycle.
- **Wait states**
  - Stimulus: `data_ok` 3 cycles after request.
  - Required: `ireq.addr` = 0x80000000 held for 3 cycles; a single valid output; then `addr` = 0x80000004.
- **Stall hold**
  - Stimulus: `data_ok` returns 0xDEADBEEF at pc 0x80000004 while `stall` = 1 for 4 cycles.
  - Required: `dataF_nxt` = {1, 0x80000004, 0xDEADBEEF} for all 4 cycles; `ireq.valid` = 0; request for 0x80000008 issued the cycle after `stall` drops.
- **Redirect during outstanding request**
  - Stimulus: `redirect` with target 0x80001000 in the 1st wait cycle of a request for 0x80000010; `data_ok` 2 cycles later.
  - Required: `addr` stays 0x80000010 until `data_ok`; no valid output for that response; next request addr = 0x80001000.
- **Redirect in HOLD, simultaneous with stall**
  - Stimulus: `redirect` to 0x80002000 with `stall` = 1.
  - Required: buffered instruction dropped, `dataF_nxt.valid` = 0, next request 0x80002000.
- **Reset and wrap-around**
  - Stimulus: reset mid-DISCARD.
  - Required: `ireq.valid` = 0 during reset; first addr 0x80000000 after release.
  - Stimulus: separately, redirect to 0xFFFFFFFFFFFFFFFC.
  - Required: the request following it goes to 0x0.
